sram_shim: RTL
==============

# sram_shim

Request/response adapter in front of the `sram` behavioural model. It converts a valid/ready request stream (read or write) into single-cycle SRAM strobes and returns one in-order response per request over a valid/ready response channel. A small response FIFO absorbs the SRAM's fixed one-cycle read latency, so the shim can sustain one request per cycle under back-pressure. It sits between interconnect masters (e.g. a `mem_to_banks` port) and one SRAM bank.

## Interface
- `NUM_WORDS`, 1024: SRAM depth; any value ≥ 2, need not be a power of two.
- `DATA_WIDTH`, 64: data word width.
- `BYTE_WIDTH`, 8: bits per strobe lane; `DATA_WIDTH % BYTE_WIDTH == 0`.
- `RSP_DEPTH`, 2: response FIFO depth, ≥ 1; 2 gives full throughput.
- Derived: `BE_WIDTH = DATA_WIDTH/BYTE_WIDTH`; `AW = $clog2(NUM_WORDS)`.

Ports (one clock; reset is asynchronous and active-low):
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `req_valid_i`  in  1  request valid.
- `req_ready_o`  out  1  request ready.
- `req_we_i`  in  1  1 = write, 0 = read.
- `req_addr_i`  in  AW  word address.
- `req_wdata_i`  in  DATA_WIDTH  write data.
- `req_be_i`  in  BE_WIDTH  byte-lane enables.
- `rsp_valid_o`  out  1  response valid.
- `rsp_ready_i`  in  1  response ready.
- `rsp_we_o`  out  1  response belongs to a write.
- `rsp_rdata_o`  out  DATA_WIDTH  read data; 0 for writes and errors.
- `rsp_err_o`  out  1  address out of range (see Configuration).
- `sram_req_o`, `sram_we_o`, `sram_addr_o`, `sram_wdata_o`, `sram_be_o`  out  SRAM strobes, same widths as the request fields.
- `sram_rdata_i`  in  DATA_WIDTH  SRAM read data, valid the cycle after a read strobe.

## Operation
- Handshake: a request is accepted when `req_valid_i & req_ready_o`. `req_valid_i` may not depend on `req_ready_o`.
- Acceptance drives the `sram_*` strobes combinationally in the same cycle. `sram_req_o = accept & ~err`. `sram_*` fields pass through from the request.
- Pending stage: register holding {valid, we, err} for the request accepted in the previous cycle.
- Occupancy = FIFO count + pending.valid. `req_ready_o = occupancy < RSP_DEPTH`. This is registered state only, with no combinational path from `rsp_ready_i`.
- Response source:
  - If the FIFO is empty and pending.valid = 1, the response bypasses the FIFO: `rsp_*` come from the pending stage, and `rsp_rdata_o = sram_rdata_i` for a good read.
  - Otherwise the response is the FIFO head.
- Pending entry placement: if a bypass response is not taken (`~rsp_ready_i`), the pending entry, including `sram_rdata_i`, is written into the FIFO that cycle. Otherwise it is consumed. Capturing `sram_rdata_i` in that same cycle is mandatory, because a later read changes it.
- Ordering: responses leave strictly in acceptance order. Every request produces exactly one response.
- Once asserted, `rsp_valid_o` and all `rsp_*` payloads stay stable until `rsp_ready_i`.
- Simultaneous FIFO push and pop is legal at any count, including full with pop.

## Timing
- Reset values: `req_ready_o` = 1, `rsp_valid_o` = 0, `rsp_we_o` = 0, `rsp_err_o` = 0, `rsp_rdata_o` = 0, `sram_req_o` = 0, FIFO empty, pending clear.
- Latency: the response is valid in the cycle after acceptance at the earliest.
- Throughput: 1 request/cycle when `rsp_ready_i` = 1 and `RSP_DEPTH` ≥ 2. With `RSP_DEPTH` = 1, at most 1 request per 2 cycles.
- Back-pressure: after `RSP_DEPTH` unconsumed responses, `req_ready_o` = 0. It rises the cycle after a pop.
- Reset mid-operation: in-flight, pending and FIFO contents are discarded with no response. SRAM writes that were already strobed are not undone.

## Configuration
- `SRAM_SHIM_ADDR_CHECK_EN` defined:
  - A request with `req_addr_i >= NUM_WORDS` is accepted but not strobed to the SRAM (`sram_req_o` = 0).
  - Its response has `rsp_err_o` = 1 and `rsp_rdata_o` = 0, and it keeps its order slot.
- `SRAM_SHIM_ADDR_CHECK_EN` undefined:
  - `rsp_err_o` is tied to 0.
  - All requests are strobed; out-of-range behaviour is the SRAM's.
  - No comparator logic is present.

## Test plan
- Reset, idle: `req_ready_o` = 1, `rsp_valid_o` = 0, `sram_req_o` = 0 on the first edge after `rst_ni` rises.
- Write then read: write 0xDEADBEEF_00000000 to addr 5 with `be` = 0xFF, then read addr 5, `rsp_ready_i` = 1 throughout.
  - Write response: `rsp_we_o` = 1, rdata 0.
  - Read response: the next cycle, rdata 0xDEADBEEF_00000000.
- Back-pressure: 4 back-to-back reads to addrs 1..4 with `rsp_ready_i` = 0.
  - Exactly 2 are accepted, then `req_ready_o` = 0.
  - After releasing `rsp_ready_i`, responses arrive in order 1..4 with stable data. Meanwhile a write to addr 1 is issued between the reads and must not corrupt the buffered data.
- Streaming: 100 alternating writes and reads with `rsp_ready_i` = 1 give 100 responses in 101 cycles, all in order.
- Address check: `NUM_WORDS` = 1000, read addr 1000.
  - With the macro: `rsp_err_o` = 1, `sram_req_o` = 0.
  - Without it: `rsp_err_o` = 0, `sram_req_o` = 1.
- Reset mid-flight: assert `rst_ni` = 0 while 2 responses are buffered. No response appears after reset, and `req_ready_o` = 1.

Source files
------------

// File: rtl/sram_shim.sv
// Valid/ready request/response adapter in front of a single-cycle-latency SRAM bank.
// Optional out-of-range address checking is enabled by defining SRAM_SHIM_ADDR_CHECK_EN.
module sram_shim #(
  parameter int unsigned NUM_WORDS  = 1024,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned BYTE_WIDTH = 8,
  parameter int unsigned RSP_DEPTH  = 2,
  localparam int unsigned BE_WIDTH  = DATA_WIDTH / BYTE_WIDTH,
  localparam int unsigned AW        = $clog2(NUM_WORDS)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [AW-1:0]         req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [BE_WIDTH-1:0]   req_be_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic                  rsp_we_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  sram_req_o,
  output logic                  sram_we_o,
  output logic [AW-1:0]         sram_addr_o,
  output logic [DATA_WIDTH-1:0] sram_wdata_o,
  output logic [BE_WIDTH-1:0]   sram_be_o,
  input  logic [DATA_WIDTH-1:0] sram_rdata_i
);

  localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);

  logic                  accept_s;
  logic                  err_s;
  logic                  ready_s;
  logic [CNT_W:0]        occ_s;

  logic                  pend_valid_r;
  logic                  pend_we_r;
  logic                  pend_err_r;
  logic [DATA_WIDTH-1:0] pend_rdata_s;

  logic [DATA_WIDTH-1:0] fifo_data_r [RSP_DEPTH];
  logic                  fifo_we_r   [RSP_DEPTH];
  logic                  fifo_err_r  [RSP_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [CNT_W-1:0]      count_r;

  logic                  fifo_empty_s;
  logic                  bypass_s;
  logic                  push_s;
  logic                  pop_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(RSP_DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

`ifdef SRAM_SHIM_ADDR_CHECK_EN
  assign err_s = ({1'b0, req_addr_i} >= (AW + 1)'(NUM_WORDS));
`else
  assign err_s = 1'b0;
`endif

  // Readiness looks only at registered occupancy, never at rsp_ready_i.
  assign occ_s        = {1'b0, count_r} + {{CNT_W{1'b0}}, pend_valid_r};
  assign ready_s      = (occ_s < (CNT_W + 1)'(RSP_DEPTH));
  assign req_ready_o  = ready_s;
  assign accept_s     = req_valid_i & ready_s;

  assign sram_req_o   = accept_s & ~err_s;
  assign sram_we_o    = req_we_i;
  assign sram_addr_o  = req_addr_i;
  assign sram_wdata_o = req_wdata_i;
  assign sram_be_o    = req_be_i;

  assign fifo_empty_s = (count_r == {CNT_W{1'b0}});
  assign bypass_s     = fifo_empty_s & pend_valid_r;
  assign pend_rdata_s = (pend_we_r | pend_err_r) ? {DATA_WIDTH{1'b0}} : sram_rdata_i;
  // A pending entry not consumed by bypass is parked in the FIFO while sram_rdata_i is still valid.
  assign push_s       = pend_valid_r & ~(bypass_s & rsp_ready_i);
  assign pop_s        = ~fifo_empty_s & rsp_ready_i;

  // Response mux: bypass from pending stage, else FIFO head, else idle zeros
  always_comb begin
    rsp_valid_o = 1'b0;
    rsp_we_o    = 1'b0;
    rsp_err_o   = 1'b0;
    rsp_rdata_o = {DATA_WIDTH{1'b0}};
    if (bypass_s) begin
      rsp_valid_o = 1'b1;
      rsp_we_o    = pend_we_r;
      rsp_err_o   = pend_err_r;
      rsp_rdata_o = pend_rdata_s;
    end else if (!fifo_empty_s) begin
      rsp_valid_o = 1'b1;
      rsp_we_o    = fifo_we_r[rd_ptr_r];
      rsp_err_o   = fifo_err_r[rd_ptr_r];
      rsp_rdata_o = fifo_data_r[rd_ptr_r];
    end else begin
      rsp_valid_o = 1'b0;
    end
  end

  // Pending stage tracks the request accepted in the previous cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_valid_r <= 1'b0;
      pend_we_r    <= 1'b0;
      pend_err_r   <= 1'b0;
    end else if (accept_s) begin
      pend_valid_r <= 1'b1;
      pend_we_r    <= req_we_i;
      pend_err_r   <= err_s;
    end else begin
      pend_valid_r <= 1'b0;
      pend_we_r    <= 1'b0;
      pend_err_r   <= 1'b0;
    end
  end

  // Response FIFO storage and pointers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      for (int i = 0; i < int'(RSP_DEPTH); i++) begin
        fifo_data_r[i] <= {DATA_WIDTH{1'b0}};
        fifo_we_r[i]   <= 1'b0;
        fifo_err_r[i]  <= 1'b0;
      end
    end else begin
      if (push_s) begin
        fifo_data_r[wr_ptr_r] <= pend_rdata_s;
        fifo_we_r[wr_ptr_r]   <= pend_we_r;
        fifo_err_r[wr_ptr_r]  <= pend_err_r;
        wr_ptr_r              <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
    end
  end

  // FIFO occupancy counter; simultaneous push and pop leaves it unchanged
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_r <= {CNT_W{1'b0}};
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule
